// File: rtl/operand_select_bcd.sv
`default_nettype none
// ============================================================================
// Module   : operand_select_bcd
// Purpose  : ALU operand multiplexers (Mux_a, Mux_b) and a registered
//            binary-to-BCD converter for the seven-segment display path.
// Ports    : clk      - system clock, BCD digit registers update on rising edge
//            reset    - asynchronous active-high, clears the BCD digits
//            reg_a    - register A value         (Mux_a data 0)
//            reg_b    - register B value         (Mux_a data 1, Mux_b data 0)
//            im       - instruction literal      (Mux_b data 1)
//            data_dm  - data-memory read value   (Mux_b data 2)
//            s_a      - Mux_a select
//            s_b      - Mux_b select
//            out_a    - ALU operand a (combinational)
//            out_b    - ALU operand b (combinational)
//            binary   - unsigned value to display
//            hundreds - BCD hundreds digit (0..2), registered
//            tens     - BCD tens digit     (0..9), registered
//            ones     - BCD ones digit     (0..9), registered
// Revision : 1.0 - initial release
// ============================================================================
module operand_select_bcd (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] reg_a,
   input  logic [7:0] reg_b,
   input  logic [7:0] im,
   input  logic [7:0] data_dm,
   input  logic [1:0] s_a,
   input  logic [1:0] s_b,
   output logic [7:0] out_a,
   output logic [7:0] out_b,
   input  logic [7:0] binary,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   // ------------------------------------------------------------------------
   // Operand multiplexers: purely combinational, independent of clk/reset.
   // ------------------------------------------------------------------------
   always_comb begin
      out_a = 8'h00;
      case (s_a)
         2'b00:   out_a = reg_a;
         2'b01:   out_a = reg_b;
         2'b10:   out_a = 8'h00;
         2'b11:   out_a = 8'h01;
         default: out_a = 8'hxx;
      endcase
   end

   always_comb begin
      out_b = 8'h00;
      case (s_b)
         2'b00:   out_b = reg_b;
         2'b01:   out_b = im;
         2'b10:   out_b = data_dm;
         2'b11:   out_b = 8'h00;
         default: out_b = 8'hxx;
      endcase
   end

   // ------------------------------------------------------------------------
   // Double-dabble, fully unrolled. Shift register layout:
   //   [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary input.
   // Before each shift, any BCD digit >= 5 gets +3 so the shift carries
   // correctly into the next decimal digit. The hundreds digit of an 8-bit
   // value never exceeds 2, so it never needs the correction.
   // ------------------------------------------------------------------------
   logic [19:0] dabble;

   always_comb begin
      dabble = {12'd0, binary};
      for (int i = 0; i < 8; i++) begin
         if (dabble[11:8] >= 4'd5)
            dabble[11:8] = dabble[11:8] + 4'd3;
         if (dabble[15:12] >= 4'd5)
            dabble[15:12] = dabble[15:12] + 4'd3;
         dabble = dabble << 1;
      end
   end

   // Registered digits so the display decoders see stable values each cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hundreds <= 4'd0;
         tens     <= 4'd0;
         ones     <= 4'd0;
      end else begin
         hundreds <= dabble[19:16];
         tens     <= dabble[15:12];
         ones     <= dabble[11:8];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_operand_select_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_select_bcd
// Purpose  : Directed self-checking bench for operand_select_bcd: mux sweeps,
//            BCD sweep and corners, asynchronous reset, concurrent activity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_select_bcd;

   logic       clk;
   logic       reset;
   logic [7:0] reg_a, reg_b, im, data_dm, binary;
   logic [1:0] s_a, s_b;
   logic [7:0] out_a, out_b;
   logic [3:0] hundreds, tens, ones;

   int n_tests = 0;
   int n_fail  = 0;

   operand_select_bcd dut (
      .clk      (clk),
      .reset    (reset),
      .reg_a    (reg_a),
      .reg_b    (reg_b),
      .im       (im),
      .data_dm  (data_dm),
      .s_a      (s_a),
      .s_b      (s_b),
      .out_a    (out_a),
      .out_b    (out_b),
      .binary   (binary),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int actual, input int expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Digits packed as 12'hHTO so expected values read as decimal numbers.
   function automatic int digits();
      return {20'd0, hundreds, tens, ones};
   endfunction

   // Move to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0]  corner_in  [8] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd200, 8'd255};
   logic [11:0] corner_exp [8] = '{12'h000, 12'h009, 12'h010, 12'h099,
                                   12'h100, 12'h199, 12'h200, 12'h255};
   logic [7:0]  mux_a_exp  [4] = '{8'h3C, 8'hA5, 8'h00, 8'h01};
   logic [7:0]  mux_b_exp  [4] = '{8'hA5, 8'h17, 8'hE2, 8'h00};

   initial begin
      reset   = 1'b1;
      reg_a   = 8'h3C;
      reg_b   = 8'hA5;
      im      = 8'h17;
      data_dm = 8'hE2;
      s_a     = 2'b00;
      s_b     = 2'b00;
      binary  = 8'd123;
      #2;
      check("reset_digits", digits(), 12'h000);
      tick();
      check("reset_holds_edge", digits(), 12'h000);

      // Mux sweeps: combinational, sampled 1 time unit after each change.
      for (int i = 0; i < 4; i++) begin
         s_a = 2'(i);
         s_b = 2'(i);
         #1;
         check($sformatf("mux_a_sel%0d", i), int'(out_a), int'(mux_a_exp[i]));
         check($sformatf("mux_b_sel%0d", i), int'(out_b), int'(mux_b_exp[i]));
      end
      s_b = 2'b01;
      #1;
      reset = 1'b0;
      #1;
      check("mux_b_reset_low", int'(out_b), 32'h17);
      reset = 1'b1;
      #1;
      check("mux_b_reset_high", int'(out_b), 32'h17);
      check("mux_a_reset_high", int'(out_a), 32'h01);

      // Leave reset away from an edge, then start conversion tests.
      @(negedge clk);
      reset = 1'b0;

      // Corner values on consecutive edges, 1-cycle latency.
      for (int i = 0; i < 8; i++) begin
         binary = corner_in[i];
         tick();
         check($sformatf("corner_%0d", corner_in[i]), digits(), int'(corner_exp[i]));
      end

      // Full sweep 0..255, checked against division-based digit formulas.
      for (int v = 0; v < 256; v++) begin
         binary = 8'(v);
         tick();
         check($sformatf("sweep_%0d", v), digits(),
               ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
         check($sformatf("legal_%0d", v),
               int'(hundreds <= 4'd2 && tens <= 4'd9 && ones <= 4'd9), 1);
      end

      // Asynchronous reset.
      binary = 8'd173;
      tick();
      check("pre_reset_173", digits(), 12'h173);
      #2;
      reset = 1'b1;
      #1;
      check("async_clear", digits(), 12'h000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset_held_%0d", i), digits(), 12'h000);
      end
      reset = 1'b0;
      #1;
      check("after_deassert_no_edge", digits(), 12'h000);
      tick();
      check("post_reset_173", digits(), 12'h173);

      // Simultaneous change: muxes respond now, digits only at the next edge.
      s_a    = 2'b00;
      s_b    = 2'b10;
      binary = 8'd58;
      #1;
      check("simul_mux_a", int'(out_a), 32'h3C);
      check("simul_mux_b", int'(out_b), 32'hE2);
      check("simul_digits_old", digits(), 12'h173);
      tick();
      check("simul_digits_new", digits(), 12'h058);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
